// File: rtl/graphics_pkg.sv
// ---------------------------------------------------------------------------
// graphics_pkg
// Shared types and helpers for the graphics drawing pipeline.
//   pixel_t       : Avalon-ST pixel beat emitted by the drawing engines
//   fb_write_t    : one queued framebuffer write (byte address + color)
//   fb_pixel_addr : linear framebuffer byte address of pixel (x, y)
// ---------------------------------------------------------------------------
package graphics_pkg;

    // Pixel stream field widths
    localparam int unsigned X_WIDTH          = 12;
    localparam int unsigned Y_WIDTH          = 12;
    localparam int unsigned COLOR_DATA_WIDTH = 16;
    localparam int unsigned PAD_WIDTH        = 8;

    // Framebuffer defaults
    localparam int unsigned FB_H_RES           = 640;
    localparam int unsigned FB_V_RES           = 480;
    localparam int unsigned FB_BYTES_PER_PIXEL = 2;
    localparam int unsigned FB_ADDR_WIDTH      = 32;

    // One pixel beat; pad carries no information
    typedef struct packed {
        logic [PAD_WIDTH-1:0]        pad;
        logic [X_WIDTH-1:0]          x;
        logic [Y_WIDTH-1:0]          y;
        logic [COLOR_DATA_WIDTH-1:0] color;
    } pixel_t;

    localparam int unsigned ST_DATA_WIDTH = $bits(pixel_t);

    // One pending framebuffer write
    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0]    addr;
        logic [COLOR_DATA_WIDTH-1:0] color;
    } fb_write_t;

    // base + (y*h_res + x)*bpp, evaluated modulo 2^FB_ADDR_WIDTH
    function automatic logic [FB_ADDR_WIDTH-1:0] fb_pixel_addr(
        input logic [X_WIDTH-1:0]       x,
        input logic [Y_WIDTH-1:0]       y,
        input logic [FB_ADDR_WIDTH-1:0] base,
        input int unsigned              h_res,
        input int unsigned              bpp
    );
        logic [FB_ADDR_WIDTH-1:0] lin;
        lin = FB_ADDR_WIDTH'(y) * FB_ADDR_WIDTH'(h_res) + FB_ADDR_WIDTH'(x);
        return base + lin * FB_ADDR_WIDTH'(bpp);
    endfunction

endpackage

// File: rtl/graphics_pixel_fifo.sv
// ---------------------------------------------------------------------------
// graphics_pixel_fifo
// Synchronous show-ahead FIFO of fb_write_t framebuffer write commands.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push/wdata : enqueue; accepted when not full, or when full with a pop
//   pop        : dequeue the head entry; ignored when empty
//   head       : current head entry (valid while !empty)
//   full/empty : status flags; count : number of stored entries
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module graphics_pixel_fifo
    import graphics_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fb_write_t              wdata,
    input  logic                   pop,
    output fb_write_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fb_write_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Push while full is legal only when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/graphics_pixel_writer.sv
// ---------------------------------------------------------------------------
// graphics_pixel_writer
// Avalon-ST pixel sink that turns each (x, y, color) beat into one Avalon-MM
// write into a linear framebuffer. Off-screen pixels are dropped and counted.
//   clk, reset      : clock, synchronous active-high reset
//   st_valid/ready  : sink handshake; st_data carries a graphics_pkg::pixel_t
//   mm_address      : framebuffer byte address of the head write
//   mm_write        : write request (held with address/data while stalled)
//   mm_writedata    : zero-extended color
//   mm_byteenable   : all ones
//   mm_waitrequest  : slave stall
//   idle            : nothing held in S1, the FIFO, or being accepted now
//   clip_count      : saturating count of dropped pixels
// Pipeline: accept -> S1 (clip + address) -> command FIFO -> MM master.
// ---------------------------------------------------------------------------
module graphics_pixel_writer
    import graphics_pkg::*;
#(
    parameter int unsigned H_RES           = FB_H_RES,
    parameter int unsigned V_RES           = FB_V_RES,
    parameter logic [31:0] FB_BASE         = 32'h0,
    parameter int unsigned BYTES_PER_PIXEL = FB_BYTES_PER_PIXEL,
    parameter int unsigned MM_ADDR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ST_DATA_WIDTH-1:0]     st_data,
    output logic [MM_ADDR_WIDTH-1:0]     mm_address,
    output logic                         mm_write,
    output logic [8*BYTES_PER_PIXEL-1:0] mm_writedata,
    output logic [BYTES_PER_PIXEL-1:0]   mm_byteenable,
    input  logic                         mm_waitrequest,
    output logic                         idle,
    output logic [15:0]                  clip_count
);

    localparam int unsigned MM_DATA_WIDTH = 8 * BYTES_PER_PIXEL;
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W         = CNT_W + 1;

    pixel_t             px;
    logic               accept;
    logic               clip_c;
    logic [FB_ADDR_WIDTH-1:0] addr_c;

    logic               s1_valid;
    logic               s1_clip;
    fb_write_t          s1_wr;

    logic               fifo_push;
    logic               fifo_pop;
    fb_write_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occupancy;

    logic               unused_bits;

    assign px     = pixel_t'(st_data);
    assign accept = st_valid && st_ready;

    // Clip test and framebuffer address for the incoming beat
    assign clip_c = (32'(px.x) >= H_RES) || (32'(px.y) >= V_RES);
    assign addr_c = FB_ADDR_WIDTH'(MM_ADDR_WIDTH'(
                        fb_pixel_addr(px.x, px.y, FB_BASE, H_RES, BYTES_PER_PIXEL)));

    // S1: holds a beat for exactly one cycle, then drains into the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_clip  <= 1'b0;
            s1_wr    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_clip     <= clip_c;
                s1_wr.addr  <= addr_c;
                s1_wr.color <= px.color;
            end
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count <= '0;
        end else if (s1_valid && s1_clip && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    // S1 never stalls: ready only admits a beat when FIFO space is reserved for it
    assign fifo_push = s1_valid && !s1_clip;
    assign fifo_pop  = mm_write && !mm_waitrequest;

    graphics_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (s1_wr),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Ready depends only on registered occupancy, never on waitrequest
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid);
    assign st_ready  = !reset && (occupancy < OCC_W'(FIFO_DEPTH));

    // Master side driven straight from the FIFO head; zeros when nothing queued
    assign mm_write      = !fifo_empty;
    assign mm_address    = fifo_empty ? '0 : MM_ADDR_WIDTH'(fifo_head.addr);
    assign mm_writedata  = fifo_empty ? '0 : MM_DATA_WIDTH'(fifo_head.color);
    assign mm_byteenable = '1;

    assign idle = !s1_valid && fifo_empty && !accept;

    assign unused_bits = ^px.pad ^ fifo_full;

endmodule
